jtframe_sdram64_arb: RTL

Command-bus arbiter for the 64-bit SDRAM controller. It shares the single SDRAM command/address bus between BANKS bank controllers and the refresh engine, using the same br/bg/busy handshake the refresh engine already speaks. Refresh has absolute priority, and banks are served round-robin. The winning requester's command and address are muxed onto the registered SDRAM pins.

---
 rtl/jtframe_sdram64_pkg.sv | 23 ++
 rtl/jtframe_sdram64_arb_if.sv | 31 +++
 rtl/jtframe_sdram64_rr.sv | 35 +++
 rtl/jtframe_sdram64_arb.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/jtframe_sdram64_pkg.sv
// Shared definitions for the 64-bit SDRAM controller: SDRAM command encodings
// ({/CS,/RAS,/CAS,/WE}) and the command-bus arbiter state encoding.
package jtframe_sdram64_pkg;

  localparam logic [3:0] CMD_LOAD_MODE  = 4'b0000;
  localparam logic [3:0] CMD_REFRESH    = 4'b0001;
  localparam logic [3:0] CMD_PRECHARGE  = 4'b0010;
  localparam logic [3:0] CMD_ACTIVE     = 4'b0011;
  localparam logic [3:0] CMD_WRITE      = 4'b0100;
  localparam logic [3:0] CMD_READ       = 4'b0101;
  localparam logic [3:0] CMD_BURST_STOP = 4'b0110;
  localparam logic [3:0] CMD_NOP        = 4'b0111;
  localparam logic [3:0] CMD_INHIBIT    = 4'b1000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    OWN   = 2'd2
  } arb_state_t;

  localparam int WD_W = 8;

endpackage

// File: rtl/jtframe_sdram64_arb_if.sv
// Command-bus sharing interface: bank/refresh requesters on one side,
// the arbiter and the registered SDRAM pins on the other.
interface jtframe_sdram64_arb_if #(
  parameter int BANKS = 4
);
  logic [BANKS-1:0]    bank_br;
  logic [BANKS-1:0]    bank_busy;
  logic [4*BANKS-1:0]  bank_cmd;
  logic [13*BANKS-1:0] bank_a;
  logic [BANKS-1:0]    bank_bg;
  logic                rfsh_br;
  logic                rfsh_busy;
  logic [3:0]          rfsh_cmd;
  logic [12:0]         rfsh_a;
  logic                rfsh_bg;
  logic [3:0]          sdram_cmd;
  logic [12:0]         sdram_a;
  logic [1:0]          sdram_ba;

  modport master (
    output bank_br, bank_busy, bank_cmd, bank_a,
    output rfsh_br, rfsh_busy, rfsh_cmd, rfsh_a,
    input  bank_bg, rfsh_bg, sdram_cmd, sdram_a, sdram_ba
  );

  modport slave (
    input  bank_br, bank_busy, bank_cmd, bank_a,
    input  rfsh_br, rfsh_busy, rfsh_cmd, rfsh_a,
    output bank_bg, rfsh_bg, sdram_cmd, sdram_a, sdram_ba
  );
endinterface

// File: rtl/jtframe_sdram64_rr.sv
// Combinational round-robin picker: first set request at or above rr, wrapping
// modulo N (N a power of two). Shared with the bank request queue.
module jtframe_sdram64_rr #(
  parameter int N = 4,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] rr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         any
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] j;

  // NOTE: every output and temporary gets a default before any branch so the
  // block stays purely combinational; a path that skips an assignment infers a latch.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = |req;
    j      = '0;
    // Scan from the farthest slot down so the nearest match is written last.
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'(int'(rr) + k);
      if (req[j]) begin
        onehot    = '0;
        onehot[j] = 1'b1;
        idx       = W'(j);
      end
    end
  end

endmodule

// File: rtl/jtframe_sdram64_arb.sv
// SDRAM command-bus arbiter: refresh has absolute priority, banks are served
// round-robin, and the owner's command/address drive the registered pins.
module jtframe_sdram64_arb
  import jtframe_sdram64_pkg::*;
#(
  parameter int BANKS  = 4,
  parameter int OWNMAX = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  jtframe_sdram64_arb_if.slave bus,
  output logic                ovf
);
  localparam int W  = $clog2(BANKS + 1);
  localparam int IW = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam logic [W-1:0] RFSH_ID = W'(BANKS);

  arb_state_t  st, st_nx;
  logic [W-1:0] owner, owner_nx, rr, rr_nx;
  logic         grant_bank, grant_rfsh;

  logic [BANKS-1:0] pick_oh;
  logic [W-1:0]     pick_idx;
  logic             pick_any;
  logic [IW-1:0]    pick_next;

  logic [3:0]  cmd_arr [BANKS];
  logic [12:0] a_arr   [BANKS];

  logic          owner_is_rfsh, owner_busy;
  logic [IW-1:0] owner_bank;
  logic [3:0]    owner_cmd;
  logic [12:0]   owner_a;
  logic [1:0]    owner_ba;

  logic [BANKS-1:0] bank_bg_q;
  logic             rfsh_bg_q;
  logic [3:0]       cmd_q;
  logic [12:0]      a_q;
  logic [1:0]       ba_q;

  logic [WD_W-1:0] wd_cnt;
  logic [WD_W:0]   wd_inc;

  for (genvar i = 0; i < BANKS; i++) begin : g_unpack
    assign cmd_arr[i] = bus.bank_cmd[4*i +: 4];
    assign a_arr[i]   = bus.bank_a[13*i +: 13];
  end

  jtframe_sdram64_rr #(.N(BANKS), .W(W)) u_rr (
    .req    (bus.bank_br),
    .rr     (rr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign pick_next     = pick_idx[IW-1:0] + IW'(1);
  assign owner_is_rfsh = (owner == RFSH_ID);
  assign owner_bank    = owner[IW-1:0];
  assign owner_busy    = owner_is_rfsh ? bus.rfsh_busy : bus.bank_busy[owner_bank];
  assign owner_cmd     = owner_is_rfsh ? bus.rfsh_cmd  : cmd_arr[owner_bank];
  assign owner_a       = owner_is_rfsh ? bus.rfsh_a    : a_arr[owner_bank];
  assign owner_ba      = owner_is_rfsh ? 2'd0          : 2'(owner_bank);

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st    <= IDLE;
      owner <= '0;
      rr    <= '0;
    end else begin
      st    <= st_nx;
      owner <= owner_nx;
      rr    <= rr_nx;
    end
  end

  always_comb begin
    st_nx      = st;
    owner_nx   = owner;
    rr_nx      = rr;
    grant_bank = 1'b0;
    grant_rfsh = 1'b0;
    unique case (st)
      IDLE: begin
        // A pending refresh blocks new bank grants until the banks go quiet.
        if (bus.rfsh_br && bus.bank_busy == '0) begin
          grant_rfsh = 1'b1;
          owner_nx   = RFSH_ID;
          st_nx      = GRANT;
        end else if (!bus.rfsh_br && pick_any) begin
          grant_bank = 1'b1;
          owner_nx   = pick_idx;
          rr_nx      = W'(pick_next);
          st_nx      = GRANT;
        end
      end
      GRANT: st_nx = OWN;
      OWN:   if (!owner_busy) st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_bg_q <= '0;
      rfsh_bg_q <= 1'b0;
    end else begin
      bank_bg_q <= grant_bank ? pick_oh : '0;
      rfsh_bg_q <= grant_rfsh;
    end
  end

  // Pins show the owner's command one cycle late; address and bank hold outside OWN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cmd_q <= CMD_NOP;
      a_q   <= '0;
      ba_q  <= '0;
    end else if (st == OWN) begin
      cmd_q <= owner_cmd;
      a_q   <= owner_a;
      ba_q  <= owner_ba;
    end else begin
      cmd_q <= CMD_NOP;
    end
  end

  assign wd_inc = {1'b0, wd_cnt} + (WD_W+1)'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_cnt <= '0;
      ovf    <= 1'b0;
    end else begin
      if (st == GRANT)
        wd_cnt <= '0;
      else if (st == OWN && wd_cnt != '1)
        wd_cnt <= wd_inc[WD_W-1:0];
      if (st == OWN && wd_inc >= (WD_W+1)'(OWNMAX))
        ovf <= 1'b1;
    end
  end

  assign bus.bank_bg   = bank_bg_q;
  assign bus.rfsh_bg   = rfsh_bg_q;
  assign bus.sdram_cmd = cmd_q;
  assign bus.sdram_a   = a_q;
  assign bus.sdram_ba  = ba_q;

endmodule
